dcache_dm_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 11 +
 rtl/dcache_line_array.sv | 50 +++++
 rtl/dcache_dm_ctrl.sv | 140 ++++++++++++++
 tb/tb_dcache_dm_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: state encoding and default-derived widths for the direct-mapped data cache
package dcache_pkg;
  localparam int DC_BLOCK_SIZE = 2;
  localparam int DC_LINE_SIZE = 32;
  localparam int DC_ADDR_SIZE = 32;
  localparam int DC_INDEX_SIZE = 3;
  localparam int DC_TAG_W = DC_ADDR_SIZE - DC_INDEX_SIZE - DC_BLOCK_SIZE - 2;
  localparam int DC_BLK_W = (2 ** DC_BLOCK_SIZE) * DC_LINE_SIZE;
  localparam int DC_BADDR_W = DC_ADDR_SIZE - DC_BLOCK_SIZE - 2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_e;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage with one combinational read port, a line-refill port and a word-write port
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int IDX_W = DC_INDEX_SIZE,
  parameter int OFF_W = DC_BLOCK_SIZE,
  parameter int WORD_W = DC_LINE_SIZE,
  parameter int TAG_W = DC_TAG_W,
  parameter int BLK_W = DC_BLK_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [BLK_W-1:0]  data_o,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [BLK_W-1:0]  fill_data_i,
  input  logic              wr_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              clr_dirty_i
);
  localparam int N = 2 ** IDX_W;
  logic [N-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [BLK_W-1:0] data_q [N];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o = tag_q[idx_i];
  assign data_o = data_q[idx_i];
  // Status bits: refill makes a line valid and clean, a word store dirties it, writeback cleans it
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_i) dirty_q[idx_i] <= 1'b1;
    else if (clr_dirty_i) dirty_q[idx_i] <= 1'b0;
  // Tag and data arrays carry no reset; valid gates their use
  always_ff @(posedge clk_i)
    if (fill_i) begin
      tag_q[idx_i] <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (wr_i) data_q[idx_i][wr_off_i*WORD_W +: WORD_W] <= wr_data_i;
endmodule

// File: rtl/dcache_dm_ctrl.sv
// dcache_dm_ctrl: direct-mapped write-back write-allocate data cache controller (DCACHE_STATS_EN adds hit/miss counters)
module dcache_dm_ctrl
  import dcache_pkg::*;
#(
  parameter int c_block_size = DC_BLOCK_SIZE,
  parameter int c_line_size = DC_LINE_SIZE,
  parameter int address_size = DC_ADDR_SIZE,
  parameter int c_index_size = DC_INDEX_SIZE
) (
  input  logic                                      c_clk_i,
  input  logic                                      c_reset_n_i,
  input  logic                                      c_read_i,
  input  logic                                      c_write_i,
  input  logic [address_size-1:0]                   c_addr_i,
  input  logic [c_line_size-1:0]                    c_wr_data_i,
  output logic [c_line_size-1:0]                    c_read_data_o,
  output logic                                      c_busywait_o,
  output logic                                      m_read_o,
  output logic                                      m_wr_o,
  output logic [address_size-c_block_size-3:0]      m_addr_o,
  output logic [(2**c_block_size)*c_line_size-1:0]  m_wr_data_o,
  input  logic                                      m_busywait_i,
  input  logic [(2**c_block_size)*c_line_size-1:0]  m_read_data_i,
  input  logic                                      m_read_done_i,
  input  logic                                      m_write_done_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                               hit_count_o,
  output logic [31:0]                               miss_count_o
`endif
);
  localparam int TAG_W = address_size - c_index_size - c_block_size - 2;
  localparam int BLK_W = (2 ** c_block_size) * c_line_size;
  localparam int BA_W = address_size - c_block_size - 2;
  state_e state_q, state_d;
  logic m_read_q, m_read_d, m_wr_q, m_wr_d;
  logic [BA_W-1:0] m_addr_q, m_addr_d, p_baddr_q, p_baddr_d;
  logic [BLK_W-1:0] m_wr_data_q, m_wr_data_d;
  logic l_valid, l_dirty;
  logic [TAG_W-1:0] l_tag;
  logic [BLK_W-1:0] l_data;
  logic unused;
  wire [BA_W-1:0] req_baddr = c_addr_i[address_size-1:c_block_size+2];
  wire [c_index_size-1:0] req_idx = req_baddr[c_index_size-1:0];
  wire [c_block_size-1:0] off = c_addr_i[c_block_size+1:2];
  wire idle = state_q == IDLE;
  wire req = c_read_i | c_write_i;
  wire hit = l_valid && l_tag == req_baddr[BA_W-1:c_index_size];
  wire victim_dirty = l_valid && l_dirty;
  wire fill_en = state_q == ALLOCATE && m_read_q && m_read_done_i;
  wire [c_index_size-1:0] idx = idle ? req_idx : p_baddr_q[c_index_size-1:0];
  assign unused = ^{c_addr_i[1:0], m_busywait_i};
  assign c_read_data_o = (idle && c_read_i && !c_write_i && hit) ? l_data[off*c_line_size +: c_line_size] : '0;
  assign c_busywait_o = c_reset_n_i && (!idle || (req && !hit));
  assign m_read_o = m_read_q;
  assign m_wr_o = m_wr_q;
  assign m_addr_o = m_addr_q;
  assign m_wr_data_o = m_wr_data_q;
  dcache_line_array #(
    .IDX_W(c_index_size), .OFF_W(c_block_size), .WORD_W(c_line_size), .TAG_W(TAG_W), .BLK_W(BLK_W)
  ) u_lines (
    .clk_i(c_clk_i),
    .rst_ni(c_reset_n_i),
    .idx_i(idx),
    .valid_o(l_valid),
    .dirty_o(l_dirty),
    .tag_o(l_tag),
    .data_o(l_data),
    .fill_i(fill_en),
    .fill_tag_i(p_baddr_q[BA_W-1:c_index_size]),
    .fill_data_i(m_read_data_i),
    .wr_i(idle && c_write_i && hit),
    .wr_off_i(off),
    .wr_data_i(c_wr_data_i),
    .clr_dirty_i(state_q == WRITEBACK && m_write_done_i)
  );
  // Miss sequencing; the write request drops on its done pulse and the read request rises one cycle later
  always_comb begin
    state_d = state_q;
    m_read_d = m_read_q;
    m_wr_d = m_wr_q;
    m_addr_d = m_addr_q;
    m_wr_data_d = m_wr_data_q;
    p_baddr_d = p_baddr_q;
    case (state_q)
      IDLE: if (req && !hit) begin
        p_baddr_d = req_baddr;
        state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        m_wr_d = victim_dirty;
        m_read_d = !victim_dirty;
        m_addr_d = victim_dirty ? {l_tag, req_idx} : req_baddr;
        m_wr_data_d = l_data;
      end
      WRITEBACK: if (m_write_done_i) begin
        m_wr_d = 1'b0;
        m_addr_d = p_baddr_q;
        state_d = ALLOCATE;
      end
      ALLOCATE: begin
        m_read_d = !fill_en;
        state_d = fill_en ? UPDATE : ALLOCATE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Controller state and registered memory-side outputs
  always_ff @(posedge c_clk_i or negedge c_reset_n_i)
    if (!c_reset_n_i) begin
      state_q <= IDLE;
      m_read_q <= 1'b0;
      m_wr_q <= 1'b0;
      m_addr_q <= '0;
      m_wr_data_q <= '0;
      p_baddr_q <= '0;
    end else begin
      state_q <= state_d;
      m_read_q <= m_read_d;
      m_wr_q <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_wr_data_q <= m_wr_data_d;
      p_baddr_q <= p_baddr_d;
    end
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic upd_q;
  assign hit_count_o = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
  // One count per CPU request; the replayed hit right after UPDATE belongs to an already counted miss
  always_ff @(posedge c_clk_i or negedge c_reset_n_i)
    if (!c_reset_n_i) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= state_q == UPDATE;
      if (idle && req && hit && !upd_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (idle && req && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dcache_dm_ctrl.sv
// tb_dcache_dm_ctrl: scoreboard bench for dcache_dm_ctrl with a block memory model
module tb_dcache_dm_ctrl;
  typedef struct {bit wr; logic [27:0] addr; logic [127:0] data;} mreq_t;
  typedef struct {bit chk; logic [31:0] data;} cresp_t;
  logic clk = 0, rst_n = 0;
  logic c_read_i = 0, c_write_i = 0, c_busywait_o;
  logic [31:0] c_addr_i = 0, c_wr_data_i = 0, c_read_data_o;
  logic m_read_o, m_wr_o, m_busywait_i, m_read_done_i, m_write_done_i;
  logic [27:0] m_addr_o;
  logic [127:0] m_wr_data_o, m_read_data_i;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif
  mreq_t mq[$];
  cresp_t cq[$];
  mreq_t me;
  cresp_t ce;
  logic [127:0] mem [logic [27:0]];
  int checks = 0, failures = 0, proto_err = 0;
  logic prev_req = 0, done_seen = 0;
  logic mwr;
  logic [27:0] maddr;

  dcache_dm_ctrl dut (
    .c_clk_i(clk), .c_reset_n_i(rst_n), .c_read_i(c_read_i), .c_write_i(c_write_i),
    .c_addr_i(c_addr_i), .c_wr_data_i(c_wr_data_i), .c_read_data_o(c_read_data_o),
    .c_busywait_o(c_busywait_o), .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_addr_o(m_addr_o),
    .m_wr_data_o(m_wr_data_o), .m_busywait_i(m_busywait_i), .m_read_data_i(m_read_data_i),
    .m_read_done_i(m_read_done_i), .m_write_done_i(m_write_done_i)
`ifdef DCACHE_STATS_EN
    , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cpu(bit r, bit w, logic [31:0] a, logic [31:0] d, bit chk, logic [31:0] e, bit exp_hit);
    int n = 0;
    cq.push_back(cresp_t'{chk, e});
    c_read_i = r; c_write_i = w; c_addr_i = a; c_wr_data_i = d;
    do begin @(negedge clk); n++; end while (c_busywait_o && n < 200);
    checks++;
    if (exp_hit ? n != 1 : (n == 1 || n >= 200)) begin
      failures++;
      $display("FAIL latency addr %h: stalled %0d cycles, required %s", a, n, exp_hit ? "1 (hit)" : "2..199 (miss)");
    end
    @(posedge clk); #1;
    c_read_i = 0; c_write_i = 0;
  endtask

  // Memory model: answers each request after two cycles with a one-cycle done pulse
  initial begin
    m_read_done_i = 0; m_write_done_i = 0; m_busywait_i = 0; m_read_data_i = '0;
    forever begin
      @(negedge clk);
      if (m_read_o || m_wr_o) begin
        mwr = m_wr_o; maddr = m_addr_o; m_busywait_i = 1;
        repeat (2) @(negedge clk);
        if (m_read_o || m_wr_o) begin
          if (mwr) mem[maddr] = m_wr_data_o;
          else m_read_data_i = mem.exists(maddr) ? mem[maddr] : 128'h0;
          if (mwr) m_write_done_i = 1; else m_read_done_i = 1;
          @(negedge clk);
          m_read_done_i = 0; m_write_done_i = 0;
        end
        m_busywait_i = 0;
      end
    end
  end

  always @(posedge clk) done_seen <= m_read_done_i | m_write_done_i;

  // Memory-side monitor: each new request is checked against the queued expectation
  always @(negedge clk) begin
    if (m_read_o && m_wr_o) proto_err++;
    if (done_seen && (m_read_o || m_wr_o)) proto_err++;
    if ((m_read_o || m_wr_o) && !prev_req) begin
      if (mq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_mem_req: got rd=%b wr=%b addr %h, required none", m_read_o, m_wr_o, m_addr_o);
      end else begin
        me = mq.pop_front();
        check("mem_kind", {127'h0, m_wr_o}, {127'h0, me.wr});
        check("mem_addr", {100'h0, m_addr_o}, {100'h0, me.addr});
        if (me.wr) check("wb_data", m_wr_data_o, me.data);
      end
    end
    prev_req = m_read_o || m_wr_o;
  end

  // CPU-side monitor: a request completes when busywait is low
  always @(negedge clk)
    if (rst_n && (c_read_i || c_write_i) && !c_busywait_o) begin
      if (cq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_cpu_resp: got completion at %h, required none", c_addr_i);
      end else begin
        ce = cq.pop_front();
        if (ce.chk) check("load_data", {96'h0, c_read_data_o}, {96'h0, ce.data});
      end
    end

  initial begin
    int n;
    mem[28'h1] = {32'h44, 32'h33, 32'h22, 32'h11};
    mem[28'h9] = {32'h9D, 32'h9C, 32'h9B, 32'h9A};
    mem[28'h2] = {32'h2D, 32'h2C, 32'h2B, 32'h2A};
    mem[28'hA] = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busywait", {127'h0, c_busywait_o}, 128'h0);
    check("rst_m_read", {127'h0, m_read_o}, 128'h0);
    check("rst_m_wr", {127'h0, m_wr_o}, 128'h0);
    check("rst_m_addr", {100'h0, m_addr_o}, 128'h0);
    check("rst_m_wr_data", m_wr_data_o, 128'h0);
    check("rst_read_data", {96'h0, c_read_data_o}, 128'h0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    mq.push_back(mreq_t'{1'b0, 28'h1, 128'h0});
    cpu(1, 0, 32'h10, 0, 1, 32'h11, 0);
    cpu(1, 0, 32'h14, 0, 1, 32'h22, 1);
    cpu(0, 1, 32'h14, 32'hDEADBEEF, 0, 0, 1);
    mq.push_back(mreq_t'{1'b1, 28'h1, {32'h44, 32'h33, 32'hDEADBEEF, 32'h11}});
    mq.push_back(mreq_t'{1'b0, 28'h9, 128'h0});
    cpu(1, 0, 32'h94, 0, 1, 32'h9B, 0);
    mq.push_back(mreq_t'{1'b0, 28'h2, 128'h0});
    cpu(1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 0);
`ifdef DCACHE_STATS_EN
    check("hit_count", {96'h0, hit_count_o}, 128'd2);
    check("miss_count", {96'h0, miss_count_o}, 128'd3);
`endif
    mq.push_back(mreq_t'{1'b1, 28'h2, {32'h2D, 32'h2C, 32'h2B, 32'hCAFEF00D}});
    mq.push_back(mreq_t'{1'b0, 28'hA, 128'h0});
    cpu(1, 0, 32'hA0, 0, 1, 32'hA1, 0);
    cpu(1, 0, 32'hA4, 0, 1, 32'hA2, 1);
    mq.push_back(mreq_t'{1'b0, 28'h1, 128'h0});
    c_read_i = 1; c_addr_i = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_read_o && n < 50);
    check("alloc_reached", {127'h0, m_read_o}, 128'h1);
    #2 rst_n = 0;
    #1;
    check("async_rst_m_read", {127'h0, m_read_o}, 128'h0);
    check("async_rst_busywait", {127'h0, c_busywait_o}, 128'h0);
    c_read_i = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    mq.push_back(mreq_t'{1'b0, 28'h1, 128'h0});
    cpu(1, 0, 32'h10, 0, 1, 32'h11, 0);
    cpu(1, 0, 32'h14, 0, 1, 32'hDEADBEEF, 1);
    repeat (3) @(posedge clk);
    check("protocol_errors", proto_err, 0);
    check("mem_queue_empty", mq.size(), 0);
    check("cpu_queue_empty", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
